// File: rtl/sad_min_tracker.sv
// sad_min_tracker
//   Sums the MACRO_DIM**2 absolute differences of one search position into a SAD
//   (column sums, then total), and tracks the minimum SAD over a full search window
//   together with its motion vector. A done pulse hands the result to mode decision.
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             1-cycle pulse: begin (or restart) a macroblock search
//   ad_valid, ad      ADs of the next search position, column i at bits [(i+1)*8*MACRO_DIM-1 -: 8*MACRO_DIM]
//   sad_valid,sad_out SAD of one position, 2 cycles after its accepted beat
//   busy              search in progress
//   done              1-cycle pulse: min_sad / mv_x / mv_y are final
//   min_sad           minimum SAD of the last completed search
//   mv_x, mv_y        signed offset of the minimum from the window centre
//
// state  | meaning
// S_IDLE | waiting for start; ad_valid ignored
// S_RUN  | accepting beats and comparing SADs
// S_DONE | result published this cycle (done=1), back to idle next
module sad_min_tracker #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  localparam int NPOS  = SEARCH_DIM - MACRO_DIM + 1,
  localparam int SAD_W = 8 + 2*$clog2(MACRO_DIM),
  localparam int MV_W  = $clog2(NPOS-1) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            ad_valid,
  input  logic [8*MACRO_DIM*MACRO_DIM-1:0] ad,
  output logic                            sad_valid,
  output logic [SAD_W-1:0]                sad_out,
  output logic                            busy,
  output logic                            done,
  output logic [SAD_W-1:0]                min_sad,
  output logic [MV_W-1:0]                 mv_x,
  output logic [MV_W-1:0]                 mv_y
);

  localparam int CW    = 8 + $clog2(MACRO_DIM);
  localparam int PW    = $clog2(NPOS);
  localparam int NTOT  = NPOS*NPOS;
  localparam int CNT_W = $clog2(NTOT+1);
  localparam logic [MV_W-1:0] MV_OFS = MV_W'((NPOS-1)/2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]    pos_x, pos_y;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept, last_beat, fin;
  logic [CW-1:0]    col_c  [MACRO_DIM];
  logic [CW-1:0]    col_s1 [MACRO_DIM];
  logic             v1, last1, last2;
  logic [PW-1:0]    x1, y1, x2, y2;
  logic [SAD_W-1:0] sad_c, run_min, min_nxt;
  logic [PW-1:0]    best_x, best_y, bx_nxt, by_nxt;

  // The start cycle itself never accepts, even when a search is being aborted.
  assign accept    = (state_q == S_RUN) && ad_valid && !start && (acc_cnt < CNT_W'(NTOT));
  assign last_beat = (acc_cnt == CNT_W'(NTOT-1));
  assign fin       = sad_valid && last2;

  always_comb begin
    for (int i = 0; i < MACRO_DIM; i++) begin
      col_c[i] = '0;
      for (int j = 0; j < MACRO_DIM; j++)
        col_c[i] = col_c[i] + CW'(ad[(i*MACRO_DIM+j)*8 +: 8]);
    end
  end

  always_comb begin
    sad_c = '0;
    for (int i = 0; i < MACRO_DIM; i++)
      sad_c = sad_c + SAD_W'(col_s1[i]);
  end

  // Strict less-than: on a tie the earlier raster position is kept.
  always_comb begin
    min_nxt = run_min;
    bx_nxt  = best_x;
    by_nxt  = best_y;
    if (sad_valid && (sad_out < run_min)) begin
      min_nxt = sad_out;
      bx_nxt  = x2;
      by_nxt  = y2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (start)    state_d = S_RUN;
        else if (fin) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x     <= '0;
      pos_y     <= '0;
      acc_cnt   <= '0;
      v1        <= 1'b0;
      last1     <= 1'b0;
      x1        <= '0;
      y1        <= '0;
      for (int i = 0; i < MACRO_DIM; i++) col_s1[i] <= '0;
      sad_valid <= 1'b0;
      sad_out   <= '0;
      last2     <= 1'b0;
      x2        <= '0;
      y2        <= '0;
      run_min   <= '1;
      best_x    <= '0;
      best_y    <= '0;
      min_sad   <= '1;
      mv_x      <= '0;
      mv_y      <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        col_s1  <= col_c;
        x1      <= pos_x;
        y1      <= pos_y;
        last1   <= last_beat;
        acc_cnt <= acc_cnt + 1'b1;
        if (pos_x == PW'(NPOS-1)) begin
          pos_x <= '0;
          pos_y <= pos_y + 1'b1;
        end else begin
          pos_x <= pos_x + 1'b1;
        end
      end

      sad_valid <= v1;
      if (v1) begin
        sad_out <= sad_c;
        x2      <= x1;
        y2      <= y1;
        last2   <= last1;
      end

      run_min <= min_nxt;
      best_x  <= bx_nxt;
      best_y  <= by_nxt;
      if (fin && !start) begin
        min_sad <= min_nxt;
        mv_x    <= MV_W'(bx_nxt) - MV_OFS;
        mv_y    <= MV_W'(by_nxt) - MV_OFS;
      end

      // Restart wins over everything above: flush in-flight beats, reset the search.
      if (start) begin
        v1        <= 1'b0;
        sad_valid <= 1'b0;
        pos_x     <= '0;
        pos_y     <= '0;
        acc_cnt   <= '0;
        run_min   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
module tb_sad_min_tracker;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ad_valid;
  logic [2047:0] ad;
  logic          sad_valid;
  logic [15:0]   sad_out;
  logic          busy;
  logic          done;
  logic [15:0]   min_sad;
  logic [5:0]    mv_x;
  logic [5:0]    mv_y;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  sad_min_tracker #(.MACRO_DIM(16), .SEARCH_DIM(48)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ad_valid(ad_valid), .ad(ad),
    .sad_valid(sad_valid), .sad_out(sad_out), .busy(busy), .done(done),
    .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  // Spread a target SAD over the 256 bytes (255 per byte until exhausted).
  task automatic set_ad(input int s);
    int rem = s;
    for (int k = 0; k < 256; k++) begin
      int b = (rem > 255) ? 255 : rem;
      ad[k*8 +: 8] = 8'(b);
      rem -= b;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    ad_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  // Raster beats with default SAD 1000 except at (ax,ay) and (bx,by); gap = bubble percentage.
  task automatic run_beats(input int nb, input int ax, input int ay, input int asad,
                           input int bx, input int by, input int bsad, input int gap);
    for (int idx = 0; idx < nb; idx++) begin
      int x = idx % 33;
      int y = idx / 33;
      int s = 1000;
      if (x == ax && y == ay) s = asad;
      if (x == bx && y == by) s = bsad;
      if (gap > 0) begin
        while ($urandom_range(99) < gap) begin
          ad_valid = 1'b0;
          step();
        end
      end
      ad_valid = 1'b1;
      set_ad(s);
      step();
    end
    ad_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      step();
      n++;
    end
  endtask

  int d0;
  logic [5:0] e_mx, e_my;

  initial begin
    rst_n = 1'b0; start = 1'b0; ad_valid = 1'b0; ad = '0;
    #12;
    chk("rst_min_sad", 32'(min_sad), 32'hFFFF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sad_valid", 32'(sad_valid), 0);
    rst_n = 1'b1;
    step();

    // T2: two consecutive beats, 1s then FFs; 2-cycle latency each
    pulse_start();
    chk("t2_busy", 32'(busy), 1);
    ad_valid = 1'b1; ad = {256{8'h01}};
    step();
    chk("t2_lat1", 32'(sad_valid), 0);
    ad = {256{8'hFF}};
    step();
    ad_valid = 1'b0;
    chk("t2_valid_a", 32'(sad_valid), 1);
    chk("t2_sad_a", 32'(sad_out), 256);
    step();
    chk("t2_valid_b", 32'(sad_valid), 1);
    chk("t2_sad_b", 32'(sad_out), 65280);
    step();
    chk("t2_bubble", 32'(sad_valid), 0);

    // T3 + T6: full search (aborts T2 search), extra beats with SAD 0 after beat 1089
    d0 = done_cnt;
    pulse_start();
    run_beats(1089, 20, 5, 37, -1, -1, 0, 0);
    ad_valid = 1'b1; set_ad(0);
    for (int i = 0; i < 25; i++) step();
    ad_valid = 1'b0;
    step();
    e_mx = 6'd4; e_my = -6'sd11;
    chk("t3_done_cnt", 32'(done_cnt - d0), 1);
    chk("t3_min_sad", 32'(min_sad), 37);
    chk("t3_mv_x", 32'(mv_x), 32'(e_mx));
    chk("t3_mv_y", 32'(mv_y), 32'(e_my));
    chk("t3_busy", 32'(busy), 0);

    // T4: tie at (3,0) and (10,10) with bubbles
    d0 = done_cnt;
    pulse_start();
    run_beats(1089, 3, 0, 0, 10, 10, 0, 30);
    wait_done(20);
    e_mx = -6'sd13; e_my = -6'sd16;
    chk("t4_done_cnt", 32'(done_cnt - d0), 1);
    chk("t4_min_sad", 32'(min_sad), 0);
    chk("t4_mv_x", 32'(mv_x), 32'(e_mx));
    chk("t4_mv_y", 32'(mv_y), 32'(e_my));

    // T5: abort after 500 beats (which held a SAD of 0), then full search
    d0 = done_cnt;
    pulse_start();
    run_beats(500, 1, 3, 0, -1, -1, 0, 0);
    pulse_start();
    run_beats(1089, 7, 30, 5, -1, -1, 0, 0);
    wait_done(20);
    for (int i = 0; i < 5; i++) step();
    e_mx = -6'sd9; e_my = 6'sd14;
    chk("t5_done_cnt", 32'(done_cnt - d0), 1);
    chk("t5_min_sad", 32'(min_sad), 5);
    chk("t5_mv_x", 32'(mv_x), 32'(e_mx));
    chk("t5_mv_y", 32'(mv_y), 32'(e_my));

    // T1: reset mid-search with the pipeline busy
    pulse_start();
    ad_valid = 1'b1; set_ad(1000);
    step(); step(); step();
    chk("t1_pre_busy", 32'(busy), 1);
    chk("t1_pre_valid", 32'(sad_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_min_sad", 32'(min_sad), 32'hFFFF);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_sad_valid", 32'(sad_valid), 0);
    chk("t1_sad_out", 32'(sad_out), 0);
    chk("t1_mv", 32'({mv_x, mv_y}), 0);
    #10 rst_n = 1'b1;
    // ad_valid still high in IDLE: must be ignored
    for (int i = 0; i < 4; i++) step();
    chk("idle_sad_valid", 32'(sad_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    ad_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
